// File: rtl/boids_pkg.sv
// Shared definitions for the boid frame writer slice.
//   - Video geometry and frame-buffer address width
//   - Boid coordinate widths and the packed table entry type
//   - Frame sequencer state encoding
//   - pix_addr(): linear pixel address y*640 + x in shift-add form
package boids_pkg;

    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int ADDR_W       = 19;
    localparam int X_W          = 10;
    localparam int Y_W          = 9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_SWAP
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } boid_pos_t;

    // y*640 + x written as (y<<9)+(y<<7)+x. The inputs carry one spare bit
    // each so a boid at the screen edge plus its square offset cannot wrap.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [Y_W:0] y,
                                                   input logic [X_W:0] x);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 9) + (yw << 7) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/boid_frame_writer_if.sv
// Bus bundle between the frame writer, the CPU register taps and the frame RAM.
//   CPU side : cpu_we, cpu_idx, cpu_x, cpu_y, num_boids
//   RAM side : fb_clear, fb_we, fb_waddr, fb_bank, fb_swap, front_sel
// Modports:
//   master - the frame writer (consumes CPU taps, drives the RAM bus)
//   slave  - the environment (drives CPU taps, observes the RAM bus)
interface boid_frame_writer_if #(
    parameter int IDX_W = 5
) ();
    import boids_pkg::*;

    logic                 cpu_we;
    logic [IDX_W-1:0]     cpu_idx;
    logic [X_W-1:0]       cpu_x;
    logic [Y_W-1:0]       cpu_y;
    logic [IDX_W:0]       num_boids;

    logic                 fb_clear;
    logic                 fb_we;
    logic [ADDR_W-1:0]    fb_waddr;
    logic                 fb_bank;
    logic                 fb_swap;
    logic                 front_sel;

    modport master (
        input  cpu_we, cpu_idx, cpu_x, cpu_y, num_boids,
        output fb_clear, fb_we, fb_waddr, fb_bank, fb_swap, front_sel
    );

    modport slave (
        output cpu_we, cpu_idx, cpu_x, cpu_y, num_boids,
        input  fb_clear, fb_we, fb_waddr, fb_bank, fb_swap, front_sel
    );

endinterface

// File: rtl/boid_pos_table.sv
// Double-buffered boid position table.
//   The pending table takes CPU writes at any time. On snap the whole pending
//   table is copied into the active table which the draw loop reads, so CPU
//   updates never tear a frame in progress.
// Ports:
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   we, widx, wx, wy  - pending-table write
//   snap              - copy pending -> active this edge
//   rd_idx            - active-table read index (combinational read)
//   rd_x, rd_y        - active-table entry at rd_idx
module boid_pos_table
    import boids_pkg::*;
#(
    parameter int MAX_BOIDS = 32,
    parameter int IDX_W     = $clog2(MAX_BOIDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic [X_W-1:0]   wx,
    input  logic [Y_W-1:0]   wy,
    input  logic             snap,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [X_W-1:0]   rd_x,
    output logic [Y_W-1:0]   rd_y
);

    boid_pos_t pending [MAX_BOIDS];
    boid_pos_t active  [MAX_BOIDS];
    boid_pos_t wr_ent;

    assign wr_ent = boid_pos_t'{x: wx, y: wy};

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MAX_BOIDS; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            if (we) begin
                pending[widx] <= wr_ent;
            end
            // A write landing on the snapshot edge is forwarded so the frame
            // being started already sees it.
            if (snap) begin
                for (int i = 0; i < MAX_BOIDS; i++) begin
                    active[i] <= (we && widx == IDX_W'(i)) ? wr_ent : pending[i];
                end
            end
        end
    end

    assign rd_x = active[rd_idx].x;
    assign rd_y = active[rd_idx].y;

endmodule

// File: rtl/boid_frame_writer.sv
// Boid frame writer: on each frame_start it snapshots the boid table, clears
// the back bank, rasterises every active boid as a BOID_SIZE x BOID_SIZE
// square (one pixel per clock, k / dy / dx order, dx fastest) and swaps banks.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   frame_start   - one-cycle pulse from the VGA controller (screen end)
//   bus           - CPU taps in, frame RAM strobes/address/bank select out
//   busy          - a frame is being produced (CLEAR through SWAP)
//   overrun       - sticky: frame_start arrived while busy
// All outputs are registered.
module boid_frame_writer
    import boids_pkg::*;
#(
    parameter int MAX_BOIDS = 32,
    parameter int IDX_W     = $clog2(MAX_BOIDS),
    parameter int BOID_SIZE = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    boid_frame_writer_if.master    bus,
    output logic                   busy,
    output logic                   overrun
);

    // Square offsets cover BOID_SIZE up to 4.
    localparam int              D_W    = 2;
    localparam logic [D_W-1:0]  D_LAST = D_W'(BOID_SIZE - 1);
    localparam logic [IDX_W:0]  N_MAX  = (IDX_W+1)'(MAX_BOIDS);
    localparam logic [IDX_W:0]  N_ONE  = (IDX_W+1)'(1);
    localparam logic [X_W:0]    X_LIM  = (X_W+1)'(VIDEO_WIDTH);
    localparam logic [Y_W:0]    Y_LIM  = (Y_W+1)'(VIDEO_HEIGHT);

    state_t            state, state_nxt;
    logic              accept;
    logic              last_pix;
    logic [IDX_W:0]    n_clamped;
    logic [IDX_W-1:0]  k_last;
    logic              n_zero;
    logic [IDX_W-1:0]  k, k_nxt;
    logic [D_W-1:0]    dy, dx, dy_nxt, dx_nxt;
    logic [X_W-1:0]    rd_x;
    logic [Y_W-1:0]    rd_y;
    logic [X_W:0]      px_x_p0;
    logic [Y_W:0]      px_y_p0;
    logic              clear_p0, swap_p0, we_p0, busy_p0;
    logic [ADDR_W-1:0] addr_p0;

    assign accept    = (state == S_IDLE) && frame_start;
    assign n_clamped = (bus.num_boids > N_MAX) ? N_MAX : bus.num_boids;
    assign last_pix  = (state == S_DRAW) && (k == k_last) &&
                       (dy == D_LAST) && (dx == D_LAST);

    boid_pos_table #(
        .MAX_BOIDS (MAX_BOIDS),
        .IDX_W     (IDX_W)
    ) u_table (
        .clock  (clock),
        .reset  (reset),
        .we     (bus.cpu_we),
        .widx   (bus.cpu_idx),
        .wx     (bus.cpu_x),
        .wy     (bus.cpu_y),
        .snap   (accept),
        .rd_idx (k_nxt),
        .rd_x   (rd_x),
        .rd_y   (rd_y)
    );

    // Frame parameters latched with the table snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            k_last <= '0;
            n_zero <= 1'b0;
        end else if (accept) begin
            k_last <= IDX_W'(n_clamped - N_ONE);
            n_zero <= (n_clamped == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (frame_start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = n_zero ? S_SWAP : S_DRAW;
            S_DRAW:  if (last_pix) state_nxt = S_SWAP;
            S_SWAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // k/dy/dx name the pixel on the outputs this cycle; the *_nxt values are
    // the pixel being registered for the next cycle. CLEAR preloads pixel 0.
    always_comb begin
        k_nxt  = '0;
        dy_nxt = '0;
        dx_nxt = '0;
        if (state == S_DRAW) begin
            k_nxt  = k;
            dy_nxt = dy;
            dx_nxt = dx + D_W'(1);
            if (dx == D_LAST) begin
                dx_nxt = '0;
                dy_nxt = dy + D_W'(1);
                if (dy == D_LAST) begin
                    dy_nxt = '0;
                    k_nxt  = k + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k  <= '0;
            dy <= '0;
            dx <= '0;
        end else begin
            k  <= k_nxt;
            dy <= dy_nxt;
            dx <= dx_nxt;
        end
    end

    // ---- p0: next-cycle outputs decoded from next state and next pixel ----
    always_comb begin
        px_x_p0  = (X_W+1)'(rd_x) + (X_W+1)'(dx_nxt);
        px_y_p0  = (Y_W+1)'(rd_y) + (Y_W+1)'(dy_nxt);
        clear_p0 = (state_nxt == S_CLEAR);
        swap_p0  = (state_nxt == S_SWAP);
        busy_p0  = (state_nxt != S_IDLE);
        // Off-screen pixels keep their slot but do not write.
        we_p0    = (state_nxt == S_DRAW) && (px_x_p0 < X_LIM) && (px_y_p0 < Y_LIM);
        addr_p0  = pix_addr(px_y_p0, px_x_p0);
    end

    // ---- p1: registered outputs ----
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.fb_clear  <= 1'b0;
            bus.fb_we     <= 1'b0;
            bus.fb_swap   <= 1'b0;
            bus.front_sel <= 1'b0;
            bus.fb_bank   <= 1'b1;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            bus.fb_clear <= clear_p0;
            bus.fb_we    <= we_p0;
            bus.fb_swap  <= swap_p0;
            busy         <= busy_p0;
            // Bank select tracks ~front_sel and only moves on the SWAP exit
            // edge, so it is stable for a whole frame.
            if (state == S_SWAP) begin
                bus.front_sel <= ~bus.front_sel;
                bus.fb_bank   <= bus.front_sel;
            end
            if (frame_start && state != S_IDLE) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        bus.fb_waddr <= addr_p0;
    end

endmodule

// File: doc/boid_frame_writer.md
Name: boid_frame_writer

Overview:
- Successor to the per-boid position registers and the screen-end draw loop. It holds an N-entry boid position table, double-buffered against CPU writes.
- On each frame_start pulse from the VGA controller, it clears the back frame buffer and rasterises every active boid as an S×S square, one pixel per clock.
- It then swaps the front and back buffers.
- It sits between the CPU register taps and a two-bank resettable 1-bit frame RAM.

Parameters:
- MAX_BOIDS, 32, number of table entries (power of 2).
- IDX_W, $clog2(MAX_BOIDS), boid index width.
- VIDEO_WIDTH, 640, horizontal pixel count.
- VIDEO_HEIGHT, 480, vertical pixel count.
- ADDR_W, 19, frame buffer address width.
- BOID_SIZE, 2, square side length in pixels (legal range 1..4).

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_we  in  1  write the pending table entry.
- cpu_idx  in  IDX_W  entry index for the write.
- cpu_x  in  10  boid x position.
- cpu_y  in  9  boid y position.
- num_boids  in  IDX_W+1  active boid count; values above MAX_BOIDS are clamped to MAX_BOIDS.
- frame_start  in  1  one-cycle pulse (VGA screenEnd).
- fb_clear  out  1  one-cycle pulse that clears the back bank.
- fb_we  out  1  pixel write strobe.
- fb_waddr  out  ADDR_W  pixel address = y*VIDEO_WIDTH + x.
- fb_bank  out  1  bank being written (always ~front_sel).
- fb_swap  out  1  one-cycle pulse when the drawn bank becomes the front bank.
- front_sel  out  1  bank currently displayed.
- busy  out  1  a frame is in progress.
- overrun  out  1  sticky flag: frame_start arrived while busy.

Behaviour:
- Pending table (MAX_BOIDS × 19 bits):
  - Written when cpu_we=1; the write is visible at the next edge.
  - cpu_we is accepted in every state.
- Active table:
  - Copied whole from the pending table on the edge where frame_start is accepted.
  - A cpu_we in that same cycle is bypassed into the snapshot.
  - num_boids (after clamping) is latched on the same edge.
- FSM states: IDLE, CLEAR, DRAW, SWAP.
  - IDLE → CLEAR on frame_start.
  - CLEAR lasts one cycle, with fb_clear=1 → DRAW. If latched num_boids=0, CLEAR → SWAP instead.
  - DRAW iterates nested counters (boid k, then dy, then dx; dx fastest) and emits one pixel per cycle.
  - Pixel coordinates are x+dx and y+dy.
  - DRAW → SWAP after the pixel with k=n-1, dy=S-1, dx=S-1.
  - SWAP lasts one cycle: fb_swap=1, and front_sel toggles on the exit edge → IDLE.
- Timing, with frame_start sampled at edge T, n boids and S=BOID_SIZE:
  - fb_clear is high in cycle T+1.
  - fb_we slots occupy T+2 .. T+1+n·S².
  - fb_swap is high in cycle T+2+n·S².
  - The new front_sel is visible from T+3+n·S².
  - busy=1 from T+1 through the SWAP cycle inclusive.
- Clipping:
  - A pixel with x+dx ≥ VIDEO_WIDTH or y+dy ≥ VIDEO_HEIGHT still consumes its cycle, but fb_we=0.
  - fb_waddr contents are don't-care on that cycle.
  - Coordinate arithmetic is 11/10 bits wide, so there is no wrap.
- Address arithmetic:
  - Computed as (y<<9)+(y<<7)+x (the ×640 form), zero-extended to ADDR_W.
  - fb_we and fb_waddr are registered together.
- fb_bank is constant for the whole frame and equals ~front_sel at frame_start.
- frame_start while busy:
  - Ignored: no restart and no snapshot.
  - overrun is set to 1 and stays set until reset.
- Reset (at any time, including mid-DRAW):
  - State → IDLE; both tables zeroed; all counters 0.
  - front_sel=0, overrun=0, busy=0.
  - fb_we, fb_clear and fb_swap are 0 in the cycle after reset is sampled.
  - No partial swap occurs.
- Outputs are all registered; the block has no combinational path from any input to any output.

Decomposition:
- Shared package boids_pkg holds VIDEO_WIDTH, VIDEO_HEIGHT, ADDR_W, X_W=10, Y_W=9, and the FSM state enum.
- One natural sub-module: boid_pos_table, the pending/active register pair with snapshot and bypass logic.
- The FSM, pixel counters and address generator stay in the top module.

Test Plan:
- S=1, num_boids=1, entry 0=(10,10), frame_start → fb_clear at T+1; one fb_we at T+2 with addr 6410; fb_swap at T+3; front_sel 0→1 at T+4.
- S=2, num_boids=1, entry (639,479) → four DRAW cycles; only the first asserts fb_we, addr 307199; the other three are clipped.
- S=2, num_boids=3, entries (0,0),(5,1),(100,200) → 12 writes in k/dy/dx order: 0,1,640,641,645,646,1285,1286,128100,128101,128740,128741; fb_bank=1 on all of them.
- num_boids=0 → fb_clear at T+1, fb_swap at T+2, no fb_we; num_boids=40 with MAX_BOIDS=32 → exactly 32·S² pixel cycles.
- cpu_we to entry 0 during DRAW → the current frame uses the old value and the next frame uses the new one; cpu_we in the same cycle as frame_start → the new value is used in this frame.
- frame_start during DRAW → overrun=1 and the draw continues unchanged; reset asserted mid-DRAW → next cycle fb_we=0, busy=0, front_sel=0, overrun=0.
